msrv32_dmem_ahb_master: RTL and testbench
=========================================

# msrv32_dmem_ahb_master

Data-memory bus master for the msrv32 core. It accepts one load or store request at a time from the execute stage and runs it as a single AHB-Lite transfer with wait-state and error handling. It returns registered read data, the response flag and the low address bits directly to the load unit, and stalls the pipeline while a transfer is outstanding. Misaligned or illegal-size requests complete locally without any bus activity.

## Interface
- No parameters; data and address widths are fixed at 32.
- ms_riscv32_mp_clk_in  in  1  core clock; all state changes on its rising edge.
- ms_riscv32_mp_rst_in  in  1  synchronous, active-high reset.
- req_valid_in  in  1  execute stage presents a memory request.
- req_write_in  in  1  1 = store, 0 = load.
- req_addr_in  in  32  byte address (iadder output).
- req_wdata_in  in  32  store data, already lane-aligned by the store unit.
- req_size_in  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_ready_out  out  1  request accepted this cycle when high together with req_valid_in.
- stall_out  out  1  pipeline stall; high whenever the FSM is not IDLE.
- hready_in  in  1  AHB HREADY.
- hresp_in  in  1  AHB HRESP (0 OKAY, 1 ERROR).
- hrdata_in  in  32  AHB HRDATA.
- haddr_out  out  32  AHB HADDR.
- htrans_out  out  2  AHB HTRANS; only IDLE (00) and NONSEQ (10) are used.
- hwrite_out  out  1  AHB HWRITE.
- hsize_out  out  3  AHB HSIZE, equal to {1'b0, size}.
- hwdata_out  out  32  AHB HWDATA.
- ms_riscv32_mp_dmdata_out  out  32  captured read data; connects to the load unit data input.
- ahb_resp_out  out  1  response flag of the last completed transfer; connects to the load unit response input.
- iadder_out_1_to_0_out  out  2  addr[1:0] of the last completed transfer.
- done_out  out  1  one-cycle pulse marking completion of a transfer or a local reject.
- misaligned_out  out  1  one-cycle pulse, coincident with done_out, for a rejected request.

## Operation
States:
- **IDLE**
  - req_ready_out = 1 and stall_out = 0.
  - On req_valid_in, register addr, write, size and wdata.
  - A request is misaligned if any of these hold: size = 11; size = 01 with addr[0] = 1; size = 10 with addr[1:0] ≠ 00.
  - Misaligned: remain in IDLE. Next cycle, done_out = misaligned_out = 1. htrans_out, ms_riscv32_mp_dmdata_out and ahb_resp_out do not change. iadder_out_1_to_0_out is updated.
  - Aligned: go to ADDR.
- **ADDR**
  - Drive htrans_out = 10 together with haddr_out, hwrite_out and hsize_out from the registered request.
  - If hready_in = 1: go to DATA, and drop htrans_out to 00 in the next cycle.
  - If hready_in = 0: hold all address-phase outputs.
- **DATA**
  - htrans_out = 00. hwdata_out holds the registered wdata.
  - Wait for hready_in = 1.
  - If hresp_in = 1 while hready_in = 0 (first error cycle): keep waiting and issue nothing new.
  - On hready_in = 1, go to IDLE and update outputs in the next cycle:
    - done_out = 1.
    - ahb_resp_out = hresp_in.
    - iadder_out_1_to_0_out = addr[1:0].
    - ms_riscv32_mp_dmdata_out = hrdata_in only for a load with hresp_in = 0; otherwise it is unchanged.

General rules:
- Only one transfer is ever outstanding.
- A new request may be accepted in the same cycle that done_out is high, because the FSM is in IDLE then.
- haddr_out, hwrite_out and hsize_out hold their last values outside ADDR.
- ms_riscv32_mp_dmdata_out, ahb_resp_out and iadder_out_1_to_0_out hold their values until the next completion.

## Timing
Reset:
- State = IDLE.
- htrans_out = 00 and every other output = 0, except req_ready_out = 1.
- Reset applied mid-transfer gives IDLE in the next cycle with htrans_out = 00 and no done_out pulse.
- The slave must tolerate an aborted data phase.

Latency, with the request accepted in cycle N:
- Zero wait states: ADDR in N+1, DATA in N+2, done_out in N+3, read data valid from N+3.
- Each hready_in = 0 cycle in ADDR or DATA adds one cycle.
- A misaligned request gives done_out in N+1.

Signal rules:
- stall_out is high in every ADDR and DATA cycle.
- done_out and misaligned_out are never high for two consecutive cycles, unless a new request was accepted in the done cycle.
- req_valid_in is ignored outside IDLE.

## Test plan
- **Aligned word load, zero wait:** addr 0x100, size 10, hrdata 0xDEADBEEF.
  - htrans_out = 10 in N+1 and 00 in N+2.
  - done_out in N+3 with ms_riscv32_mp_dmdata_out = 0xDEADBEEF, ahb_resp_out = 0, iadder_out_1_to_0_out = 00.
- **Byte store with 2 data-phase waits:** addr 0x203, size 00, wdata 0x7F000000.
  - hsize_out = 000, hwrite_out = 1.
  - hwdata_out = 0x7F000000 held through both wait cycles.
  - done_out in N+5.
  - ms_riscv32_mp_dmdata_out is unchanged.
- **Error response on a load:** data phase gives hresp_in = 1 with hready_in = 0, then hresp_in = 1 with hready_in = 1.
  - ahb_resp_out = 1 and done_out pulses.
  - ms_riscv32_mp_dmdata_out keeps its previous value.
- **Misaligned requests:** halfword at 0x101, word at 0x102, size 11.
  - Each gives done_out = misaligned_out = 1 at N+1.
  - htrans_out never leaves 00.
- **Back-to-back requests and ADDR wait:** req_valid_in is held high for two loads, with hready_in = 0 for one ADDR cycle.
  - The second request is accepted in the done cycle of the first.
  - haddr_out is held during the ADDR wait.
  - stall_out is high throughout both transfers.
- **Reset in DATA:** assert reset while waiting in DATA.
  - Next cycle: htrans_out = 00, all outputs = 0, no done_out.
  - A subsequent load completes normally.

Source files
------------

// File: rtl/msrv32_dmem_ahb_master.sv
// Data-memory AHB-Lite master for the msrv32 core: one load/store at a time,
// misaligned or illegal-size requests are completed locally without bus activity.
module msrv32_dmem_ahb_master (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  output logic        req_ready_out,
  output logic        stall_out,
  input  logic        hready_in,
  input  logic        hresp_in,
  input  logic [31:0] hrdata_in,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_resp_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic        done_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        misaligned;
  logic        complete;

  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [31:0] hwdata_q;
  logic [31:0] dmdata_q;
  logic        resp_q;
  logic [1:0]  ia_q;
  logic        done_q;
  logic        mis_q;

  assign accept   = (state_q == S_IDLE) && req_valid_in;
  assign complete = (state_q == S_DATA) && hready_in;

  always_comb begin
    misaligned = 1'b0;
    case (req_size_in)
      2'b01:   misaligned = req_addr_in[0];
      2'b10:   misaligned = |req_addr_in[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid_in && !misaligned) state_d = S_ADDR;
      S_ADDR:  if (hready_in) state_d = S_DATA;
      S_DATA:  if (hready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_out = 1'b0;
    stall_out     = 1'b1;
    htrans_out    = 2'b00;
    case (state_q)
      S_IDLE: begin
        req_ready_out = 1'b1;
        stall_out     = 1'b0;
      end
      S_ADDR:  htrans_out = 2'b10;
      default: htrans_out = 2'b00;
    endcase
  end

  // Address-phase registers load only for aligned requests so they hold outside ADDR.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hwdata_q <= '0;
      dmdata_q <= '0;
      resp_q   <= 1'b0;
      ia_q     <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      if (accept) begin
        if (misaligned) begin
          done_q <= 1'b1;
          mis_q  <= 1'b1;
          ia_q   <= req_addr_in[1:0];
        end else begin
          haddr_q  <= req_addr_in;
          hwrite_q <= req_write_in;
          hsize_q  <= {1'b0, req_size_in};
          hwdata_q <= req_wdata_in;
        end
      end
      if (complete) begin
        done_q <= 1'b1;
        resp_q <= hresp_in;
        ia_q   <= haddr_q[1:0];
        if (!hwrite_q && !hresp_in) begin
          dmdata_q <= hrdata_in;
        end
      end
    end
  end

  assign haddr_out                = haddr_q;
  assign hwrite_out               = hwrite_q;
  assign hsize_out                = hsize_q;
  assign hwdata_out               = hwdata_q;
  assign ms_riscv32_mp_dmdata_out = dmdata_q;
  assign ahb_resp_out             = resp_q;
  assign iadder_out_1_to_0_out    = ia_q;
  assign done_out                 = done_q;
  assign misaligned_out           = mis_q;

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// Bench for msrv32_dmem_ahb_master: stimulus tasks schedule per-cycle expectations,
// and a negedge compare process checks every output against them.
module tb_msrv32_dmem_ahb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;

  logic        req_ready, stall, hwrite, resp, done, mis;
  logic [31:0] haddr, hwdata, dmdata;
  logic [1:0]  htrans, ia;
  logic [2:0]  hsize;

  msrv32_dmem_ahb_master dut (
    .ms_riscv32_mp_clk_in     (clk),
    .ms_riscv32_mp_rst_in     (rst),
    .req_valid_in             (req_valid),
    .req_write_in             (req_write),
    .req_addr_in              (req_addr),
    .req_wdata_in             (req_wdata),
    .req_size_in              (req_size),
    .req_ready_out            (req_ready),
    .stall_out                (stall),
    .hready_in                (hready),
    .hresp_in                 (hresp),
    .hrdata_in                (hrdata),
    .haddr_out                (haddr),
    .htrans_out               (htrans),
    .hwrite_out               (hwrite),
    .hsize_out                (hsize),
    .hwdata_out               (hwdata),
    .ms_riscv32_mp_dmdata_out (dmdata),
    .ahb_resp_out             (resp),
    .iadder_out_1_to_0_out    (ia),
    .done_out                 (done),
    .misaligned_out           (mis)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Completion events: cycle of the done pulse and the sticky values it leaves behind.
  typedef struct {
    int          c;
    bit          mis;
    bit          upd_data;
    logic [31:0] data;
    bit          upd_resp;
    bit          resp;
    logic [1:0]  ia;
  } done_t;

  done_t       dq[$];
  done_t       cur;
  bit          exp_busy   [int];
  bit          exp_addrph [int];
  logic [31:0] exp_haddr  [int];
  logic [3:0]  exp_hctl   [int];
  logic [31:0] exp_hwdata [int];

  logic [31:0] m_data, m_haddr;
  logic [3:0]  m_hctl;
  logic [1:0]  m_ia;
  bit          m_resp, e_done, e_mis, e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_q) begin
        m_data = '0; m_resp = 1'b0; m_ia = '0; m_haddr = '0; m_hctl = '0;
        dq.delete();
        chk("rst_ready",  32'(req_ready), 32'd1);
        chk("rst_stall",  32'(stall),     32'd0);
        chk("rst_htrans", 32'(htrans),    32'd0);
        chk("rst_haddr",  haddr,          32'd0);
        chk("rst_hctl",   32'({hwrite, hsize}), 32'd0);
        chk("rst_hwdata", hwdata,         32'd0);
        chk("rst_dmdata", dmdata,         32'd0);
        chk("rst_resp",   32'(resp),      32'd0);
        chk("rst_ia",     32'(ia),        32'd0);
        chk("rst_done",   32'(done),      32'd0);
        chk("rst_mis",    32'(mis),       32'd0);
      end else begin
        e_done = 1'b0;
        e_mis  = 1'b0;
        if (dq.size() > 0 && dq[0].c == cyc) begin
          cur    = dq.pop_front();
          e_done = 1'b1;
          e_mis  = cur.mis;
          if (cur.upd_data) m_data = cur.data;
          if (cur.upd_resp) m_resp = cur.resp;
          m_ia = cur.ia;
        end
        if (exp_addrph.exists(cyc)) begin
          m_haddr = exp_haddr[cyc];
          m_hctl  = exp_hctl[cyc];
        end
        e_busy = exp_busy.exists(cyc);
        chk("htrans", 32'(htrans), exp_addrph.exists(cyc) ? 32'd2 : 32'd0);
        chk("stall",  32'(stall),  32'(e_busy));
        chk("ready",  32'(req_ready), 32'(!e_busy));
        chk("haddr",  haddr, m_haddr);
        chk("hctl",   32'({hwrite, hsize}), 32'(m_hctl));
        if (exp_hwdata.exists(cyc)) chk("hwdata", hwdata, exp_hwdata[cyc]);
        chk("done",   32'(done),   32'(e_done));
        chk("mis",    32'(mis),    32'(e_mis));
        chk("dmdata", dmdata,      m_data);
        chk("resp",   32'(resp),   32'(m_resp));
        chk("ia",     32'(ia),     32'(m_ia));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle and play the slave side; returns in the done cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input int aw, input int dw,
                      input logic [31:0] rdata, input bit err, input bit hold);
    bit    bad;
    done_t d;
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_size = size;
    $display("[TB] cyc=%0d req wr=%0d addr=%h size=%0d aw=%0d dw=%0d err=%0d",
             cyc, wr, addr, size, aw, dw, err);
    if (bad) begin
      d.c = cyc + 1; d.mis = 1'b1; d.upd_data = 1'b0; d.data = '0;
      d.upd_resp = 1'b0; d.resp = 1'b0; d.ia = addr[1:0];
      dq.push_back(d);
      tick();
      if (!hold) req_valid = 1'b0;
    end else begin
      tick();
      if (!hold) req_valid = 1'b0;
      for (int i = 0; i <= aw; i++) begin
        hready = (i == aw);
        exp_busy[cyc] = 1'b1; exp_addrph[cyc] = 1'b1;
        exp_haddr[cyc] = addr; exp_hctl[cyc] = {wr, 1'b0, size};
        tick();
      end
      for (int i = 0; i <= dw; i++) begin
        hready = (i == dw);
        hresp  = err;
        hrdata = (i == dw) ? rdata : ~rdata;
        exp_busy[cyc] = 1'b1; exp_hwdata[cyc] = wdata;
        if (i == dw) begin
          d.c = cyc + 1; d.mis = 1'b0; d.upd_data = !wr && !err; d.data = rdata;
          d.upd_resp = 1'b1; d.resp = err; d.ia = addr[1:0];
          dq.push_back(d);
        end
        tick();
      end
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0BAD_F00D;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    xfer(1'b0, 32'h100, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("pin_load_done", 32'(done), 32'd1);
    chk("pin_load_data", dmdata, 32'hDEAD_BEEF);
    tick();

    xfer(1'b1, 32'h203, 32'h7F00_0000, 2'b00, 0, 2, 32'h1111_2222, 1'b0, 1'b0);
    chk("pin_store_done", 32'(done), 32'd1);
    chk("pin_store_data", dmdata, 32'hDEAD_BEEF);
    chk("pin_store_ia",   32'(ia), 32'd3);
    tick();

    xfer(1'b0, 32'h104, 32'h0, 2'b10, 0, 1, 32'h1234_5678, 1'b1, 1'b0);
    chk("pin_err_resp", 32'(resp), 32'd1);
    chk("pin_err_data", dmdata, 32'hDEAD_BEEF);
    tick();

    xfer(1'b0, 32'h101, 32'h0, 2'b01, 0, 0, 32'h0, 1'b0, 1'b0);
    chk("pin_mis_half", 32'({done, mis, ia}), 32'b1101);
    tick();
    xfer(1'b0, 32'h102, 32'h0, 2'b10, 0, 0, 32'h0, 1'b0, 1'b0);
    chk("pin_mis_word", 32'({done, mis, ia}), 32'b1110);
    tick();
    xfer(1'b1, 32'h200, 32'h55, 2'b11, 0, 0, 32'h0, 1'b0, 1'b0);
    chk("pin_mis_size", 32'({done, mis, ia}), 32'b1100);
    chk("pin_mis_resp", 32'(resp), 32'd1);
    tick();

    xfer(1'b0, 32'h400, 32'h0, 2'b10, 1, 0, 32'hA5A5_0001, 1'b0, 1'b1);
    chk("pin_b2b_first", dmdata, 32'hA5A5_0001);
    xfer(1'b0, 32'h404, 32'h0, 2'b10, 0, 0, 32'h5A5A_0002, 1'b0, 1'b0);
    chk("pin_b2b_second", dmdata, 32'h5A5A_0002);
    chk("pin_b2b_resp",   32'(resp), 32'd0);
    tick();

    // Load aborted by reset while its data phase is waiting.
    $display("[TB] cyc=%0d req wr=0 addr=00000300 size=2 reset in data phase", cyc);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_size = 2'b10; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0; hready = 1'b1;
    exp_busy[cyc] = 1'b1; exp_addrph[cyc] = 1'b1;
    exp_haddr[cyc] = 32'h300; exp_hctl[cyc] = 4'b0010;
    tick();
    hready = 1'b0; hrdata = 32'hFFFF_0000;
    exp_busy[cyc] = 1'b1; exp_hwdata[cyc] = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0; hready = 1'b1;
    chk("pin_rst_done",   32'(done), 32'd0);
    chk("pin_rst_htrans", 32'(htrans), 32'd0);
    tick();

    xfer(1'b0, 32'h308, 32'h0, 2'b10, 0, 0, 32'h600D_CAFE, 1'b0, 1'b0);
    chk("pin_post_rst_data", dmdata, 32'h600D_CAFE);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
